// File: rtl/led_pkg.sv
// ============================================================================
// Module   : led_pkg
// Brief    : Shared defaults, level type and sizing helpers for led_fader.
// Revision : 1.0
// ============================================================================
`default_nettype none

package led_pkg;

    localparam int c_nch      = 5;
    localparam int c_pwm_bits = 4;
    localparam int c_fade_div = 4096;

    typedef logic [c_pwm_bits-1:0] level_t;

    function automatic int max_level(input int pwm_bits);
        return (1 << pwm_bits) - 1;
    endfunction

    // A prescaler of 1 still needs a one-bit counter to keep widths legal.
    function automatic int div_width(input int fade_div);
        return (fade_div > 1) ? $clog2(fade_div) : 1;
    endfunction

    localparam int c_max_level = max_level(c_pwm_bits);
    localparam int c_div_w     = div_width(c_fade_div);

endpackage

`default_nettype wire

// File: rtl/led_fader_if.sv
// ============================================================================
// Module   : led_fader_if
// Brief    : LED target vector in, PWM drive and fade status out.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface led_fader_if
    import led_pkg::*;
#(
    parameter int NCH = c_nch
);

    logic [NCH-1:0] led_in;
    logic [NCH-1:0] led_out;
    logic [NCH-1:0] fading;

    modport master (
        output led_in,
        input  led_out,
        input  fading
    );

    modport slave (
        input  led_in,
        output led_out,
        output fading
    );

endinterface

`default_nettype wire

// File: rtl/led_fader_ch.sv
// ============================================================================
// Module   : led_fader_ch
// Brief    : One LED channel: input flop, saturating fade level, PWM compare.
// Revision : 1.0
// ============================================================================
`default_nettype none

module led_fader_ch
    import led_pkg::*;
#(
    parameter int PWM_BITS = c_pwm_bits
) (
    input  wire logic                clk,
    input  wire logic                rst,
    input  wire logic                step,
    input  wire logic [PWM_BITS-1:0] pwm_cnt,
    input  wire logic                led_in,
    output logic                     led_out,
    output logic                     fading
);

    localparam logic [PWM_BITS-1:0] c_max = PWM_BITS'(max_level(PWM_BITS));

    logic                r_led_q;
    logic [PWM_BITS-1:0] r_level;
    logic                r_led_out;
    logic                r_fading;

    logic [PWM_BITS-1:0] w_level_nxt;
    logic                w_led_out;
    logic                w_fading;

    // A reversal simply changes direction from wherever the level currently is.
    always_comb begin
        w_level_nxt = r_level;
        if (step) begin
            if (r_led_q && (r_level != c_max)) begin
                w_level_nxt = r_level + 1'b1;
            end else if (!r_led_q && (r_level != '0)) begin
                w_level_nxt = r_level - 1'b1;
            end
        end
    end

    // Full level is forced high; otherwise level L yields L high cycles per period.
    always_comb begin
        w_led_out = 1'b0;
        if (r_level == c_max) begin
            w_led_out = 1'b1;
        end else if (r_level != '0) begin
            w_led_out = (pwm_cnt < r_level);
        end
        w_fading = (r_level != (r_led_q ? c_max : '0));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_led_q   <= 1'b0;
            r_level   <= '0;
            r_led_out <= 1'b0;
            r_fading  <= 1'b0;
        end else begin
            r_led_q   <= led_in;
            r_level   <= w_level_nxt;
            r_led_out <= w_led_out;
            r_fading  <= w_fading;
        end
    end

    assign led_out = r_led_out;
    assign fading  = r_fading;

endmodule

`default_nettype wire

// File: rtl/led_fader.sv
// ============================================================================
// Module   : led_fader
// Brief    : NCH-channel LED fader with shared PWM counter and fade prescaler.
// Revision : 1.0
// ============================================================================
`default_nettype none

module led_fader
    import led_pkg::*;
#(
    parameter int NCH      = c_nch,
    parameter int PWM_BITS = c_pwm_bits,
    parameter int FADE_DIV = c_fade_div
) (
    input  wire logic   clk,
    input  wire logic   rst,
    led_fader_if.slave  led
);

    localparam int                 c_div_w    = div_width(FADE_DIV);
    localparam logic [c_div_w-1:0] c_div_last = c_div_w'(FADE_DIV - 1);

    logic [c_div_w-1:0]  r_div_cnt;
    logic [PWM_BITS-1:0] r_pwm_cnt;
    logic                w_step;
    logic [NCH-1:0]      w_led_out;
    logic [NCH-1:0]      w_fading;

    assign w_step = (r_div_cnt == c_div_last);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div_cnt <= '0;
            r_pwm_cnt <= '0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + 1'b1;
            if (w_step) begin
                r_div_cnt <= '0;
            end else begin
                r_div_cnt <= r_div_cnt + 1'b1;
            end
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        led_fader_ch #(
            .PWM_BITS (PWM_BITS)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .step    (w_step),
            .pwm_cnt (r_pwm_cnt),
            .led_in  (led.led_in[i]),
            .led_out (w_led_out[i]),
            .fading  (w_fading[i])
        );
    end

    assign led.led_out = w_led_out;
    assign led.fading  = w_fading;

endmodule

`default_nettype wire

// File: tb/tb_led_fader.sv
// ============================================================================
// Module   : tb_led_fader
// Brief    : Three faders (FADE_DIV 4, 64, 1) against a time-based reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_led_fader;

    localparam int c_nd   = 3;
    localparam int c_max  = 15;
    localparam int c_per  = 16;
    localparam int c_fdiv [c_nd] = '{4, 64, 1};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] din  [c_nd];
    logic [4:0] dout [c_nd];
    logic [4:0] dfad [c_nd];

    always #5 clk = ~clk;

    led_fader_if #(.NCH(5)) if_a ();
    led_fader_if #(.NCH(5)) if_b ();
    led_fader_if #(.NCH(5)) if_c ();

    led_fader #(.NCH(5), .PWM_BITS(4), .FADE_DIV(4))  u_a (.clk(clk), .rst(rst), .led(if_a.slave));
    led_fader #(.NCH(5), .PWM_BITS(4), .FADE_DIV(64)) u_b (.clk(clk), .rst(rst), .led(if_b.slave));
    led_fader #(.NCH(5), .PWM_BITS(4), .FADE_DIV(1))  u_c (.clk(clk), .rst(rst), .led(if_c.slave));

    assign if_a.led_in = din[0];
    assign if_b.led_in = din[1];
    assign if_c.led_in = din[2];
    assign dout[0] = if_a.led_out;
    assign dout[1] = if_b.led_out;
    assign dout[2] = if_c.led_out;
    assign dfad[0] = if_a.fading;
    assign dfad[1] = if_b.fading;
    assign dfad[2] = if_c.fading;

    typedef struct {
        int         k;
        logic [4:0] o;
        logic [4:0] f;
    } exp_t;

    exp_t sbq [$];

    // Reference state: elapsed cycles since reset, integer level, sampled target.
    int         t   [c_nd];
    int         lvl [c_nd][5];
    logic [4:0] q   [c_nd];

    int vectors    = 0;
    int miscompares = 0;

    always @(posedge clk) begin
        for (int k = 0; k < c_nd; k++) begin
            exp_t e;
            e.k = k;
            e.o = '0;
            e.f = '0;
            if (rst) begin
                t[k] = 0;
                q[k] = '0;
                for (int c = 0; c < 5; c++) lvl[k][c] = 0;
            end else begin
                int  phase;
                bit  stp;
                phase = t[k] % c_per;
                stp   = ((t[k] % c_fdiv[k]) == c_fdiv[k] - 1);
                for (int c = 0; c < 5; c++) begin
                    if (lvl[k][c] == c_max)  e.o[c] = 1'b1;
                    else                     e.o[c] = (phase < lvl[k][c]);
                    e.f[c] = (lvl[k][c] != (q[k][c] ? c_max : 0));
                    if (stp) begin
                        if (q[k][c]) lvl[k][c] = (lvl[k][c] < c_max) ? lvl[k][c] + 1 : c_max;
                        else         lvl[k][c] = (lvl[k][c] > 0) ? lvl[k][c] - 1 : 0;
                    end
                end
                q[k] = din[k];
                t[k] = t[k] + 1;
            end
            sbq.push_back(e);
        end
    end

    always @(negedge clk) begin
        while (sbq.size() > 0) begin
            exp_t e;
            e = sbq.pop_front();
            vectors++;
            if (dout[e.k] !== e.o) begin
                miscompares++;
                $display("FAIL led_out dut%0d t=%0t: got %b expected %b", e.k, $time, dout[e.k], e.o);
            end
            vectors++;
            if (dfad[e.k] !== e.f) begin
                miscompares++;
                $display("FAIL fading dut%0d t=%0t: got %b expected %b", e.k, $time, dfad[e.k], e.f);
            end
        end
    end

    initial begin
        bit reversed;
        reversed = 1'b0;
        for (int k = 0; k < c_nd; k++) din[k] = 5'h1F;

        // Reset held with all targets high.
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        rst = 1'b1;
        @(negedge clk);
        din[0] = 5'b00001;
        din[1] = 5'b00001;
        din[2] = 5'b10101;
        rst = 1'b0;

        // Fade-up, duty accuracy, reversal and a simultaneous swap.
        for (int c = 0; c < 1100; c++) begin
            @(negedge clk);
            if (c == 20)  din[2] = 5'b01010;
            if (c == 40)  din[2] = 5'b10101;
            if (c == 80)  din[0] = 5'b00101;
            if (!reversed && din[0][2] && lvl[0][2] == 7) begin
                din[0]   = 5'b00001;
                reversed = 1'b1;
            end
        end

        // Mid-fade reset on all channels.
        for (int k = 0; k < c_nd; k++) din[k] = 5'h00;
        repeat (80) @(negedge clk);
        for (int k = 0; k < c_nd; k++) din[k] = 5'h1F;
        repeat (34) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (80) @(negedge clk);

        // Random targets with occasional reset pulses.
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 199) == 0);
            for (int k = 0; k < c_nd; k++) begin
                if ($urandom_range(0, 23) == 0) din[k] = 5'($urandom);
            end
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
